bitscan_cond_unit: RTL

- Multi-cycle, parametrised successor to the single-cycle branch-compare logic. Sits in the E stage beside the multiply/divide unit.
- Iteratively computes popcount, highest-set-bit index, popcount equality and a wrapped-sum threshold test.
- Uses a start/busy/done handshake so the hazard unit stalls on `busy` exactly as it does for the MDU.

---
 rtl/bitscan_cond_unit_pkg.sv | 24 ++
 rtl/bitscan_cond_unit_chunk.sv | 29 ++
 rtl/bitscan_cond_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bitscan_cond_unit_pkg.sv
// Shared encodings for the iterative bit-scan / condition unit.
// Optional build macro: BITSCAN_EARLY_EXIT_EN.
package bitscan_cond_unit_pkg;

  typedef enum logic [2:0] {
    POPCNT_OP  = 3'd0,
    HIGHONE_OP = 3'd1,
    SUMLT_OP   = 3'd2,
    POPEQ_OP   = 3'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [31:0] THRESH_DEFAULT = 32'h0000_6000;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/bitscan_cond_unit_chunk.sv
// Combinational STEP-bit slice counter: popcount, any-one flag and
// index of the highest set bit within the slice.
module bit_chunk_count
  import bitscan_cond_unit_pkg::*;
#(
  parameter int STEP = 4,
  localparam int CW = $clog2(STEP + 1),
  localparam int IW = clog2_min1(STEP)
) (
  input  logic [STEP-1:0] bits_i,
  output logic [CW-1:0]   cnt_o,
  output logic            any_o,
  output logic [IW-1:0]   idx_o
);

  always_comb begin
    cnt_o = '0;
    idx_o = '0;
    for (int i = 0; i < STEP; i++) begin
      if (bits_i[i]) begin
        cnt_o = cnt_o + CW'(1);
        idx_o = IW'(i);
      end
    end
  end

  assign any_o = |bits_i;

endmodule

// File: rtl/bitscan_cond_unit.sv
// Multi-cycle popcount / highest-one / sum-threshold / popcount-equal unit.
// Optional build macro: BITSCAN_EARLY_EXIT_EN (HIGHONE stops at first hit).
module bitscan_cond_unit
  import bitscan_cond_unit_pkg::*;
#(
  parameter int          WIDTH  = 32,
  parameter int          STEP   = 4,
  parameter logic [31:0] THRESH = THRESH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cond
);

  localparam int N   = WIDTH / STEP;
  localparam int KW  = clog2_min1(N);
  localparam int PW  = $clog2(WIDTH + 1);
  localparam int SCW = $clog2(STEP + 1);
  localparam int SIW = clog2_min1(STEP);
  localparam logic [WIDTH-1:0] THR = WIDTH'(THRESH);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [KW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    pa_q, pa_d, pb_q, pb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             fnd_q, fnd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cnd_q, cnd_d;

  logic [SCW-1:0]   cnt_a, cnt_b;
  logic             any_a, any_b;
  logic [SIW-1:0]   idx_a, idx_b;
  logic             unused_b;

  // MSB chunk is examined first so the first hit is the highest one
  bit_chunk_count #(.STEP(STEP)) u_cnt_a (
    .bits_i (a_q[WIDTH-1 -: STEP]),
    .cnt_o  (cnt_a),
    .any_o  (any_a),
    .idx_o  (idx_a)
  );

  bit_chunk_count #(.STEP(STEP)) u_cnt_b (
    .bits_i (b_q[WIDTH-1 -: STEP]),
    .cnt_o  (cnt_b),
    .any_o  (any_b),
    .idx_o  (idx_b)
  );

  assign unused_b = ^{any_b, idx_b};

  logic early;
`ifdef BITSCAN_EARLY_EXIT_EN
  assign early = (op_q == HIGHONE_OP) && any_a;
`else
  assign early = 1'b0;
`endif

  int               base_i;
  logic [WIDTH-1:0] hi_n, sum;
  logic [PW-1:0]    pa_n, pb_n;
  logic             fnd_n, chunked, last, accept;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    hi_d    = hi_q;
    fnd_d   = fnd_q;
    res_d   = res_q;
    cnd_d   = cnd_q;

    base_i  = (N - 1 - int'(cnt_q)) * STEP;
    pa_n    = pa_q + PW'(cnt_a);
    pb_n    = pb_q + PW'(cnt_b);
    fnd_n   = fnd_q | any_a;
    hi_n    = (fnd_q || !any_a) ? hi_q
              : WIDTH'(base_i) + WIDTH'(idx_a);
    sum     = a_q + b_q;
    chunked = (op_q == POPCNT_OP) || (op_q == HIGHONE_OP)
              || (op_q == POPEQ_OP);
    last    = !chunked || (cnt_q == KW'(N - 1)) || early;
    accept  = start && !flush && (state_q != S_RUN);

    unique case (state_q)
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          a_d   = a_q << STEP;
          b_d   = b_q << STEP;
          cnt_d = cnt_q + KW'(1);
          pa_d  = pa_n;
          pb_d  = pb_n;
          hi_d  = hi_n;
          fnd_d = fnd_n;
          if (last) begin
            state_d = S_DONE;
            cnt_d   = '0;
            res_d   = '0;
            cnd_d   = 1'b0;
            case (op_q)
              POPCNT_OP: begin
                res_d = WIDTH'(pa_n);
                cnd_d = (pa_n != '0);
              end
              HIGHONE_OP: begin
                res_d = fnd_n ? hi_n : '1;
                cnd_d = fnd_n;
              end
              SUMLT_OP: begin
                cnd_d = (sum < THR);
                res_d = WIDTH'(sum < THR);
              end
              POPEQ_OP: begin
                cnd_d = (pa_n == pb_n);
                res_d = WIDTH'(pa_n == pb_n);
              end
              default: ;
            endcase
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_RUN;
          op_d    = op;
          a_d     = src_a;
          b_d     = src_b;
          cnt_d   = '0;
          pa_d    = '0;
          pb_d    = '0;
          hi_d    = '0;
          fnd_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      pa_q    <= '0;
      pb_q    <= '0;
      hi_q    <= '0;
      fnd_q   <= 1'b0;
      res_q   <= '0;
      cnd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      hi_q    <= hi_d;
      fnd_q   <= fnd_d;
      res_q   <= res_d;
      cnd_q   <= cnd_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign cond   = cnd_q;

endmodule
